// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and the fetch-stage state encoding.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    StReq,
    StHold,
    StDrop
  } fetch_state_e;

endpackage

// File: rtl/pc_redirect_mux.sv
// Decode-stage redirect detection and target selection (jr > j > branch), word aligned.
module pc_redirect_mux
  import mips_pkg::*;
(
  input  logic               validD,
  input  logic               stallD,
  input  logic               branch_takenD,
  input  logic [INSTR_W-1:0] branch_targetD,
  input  logic               jumpD,
  input  logic [INSTR_W-1:0] jump_targetD,
  input  logic               jrD,
  input  logic [INSTR_W-1:0] jr_targetD,
  output logic               redirect,
  output logic [INSTR_W-1:0] target
);

  logic [INSTR_W-1:0] target_sel;

  always_comb begin
    redirect = validD & ~stallD & (jrD | jumpD | branch_takenD);
    if (jrD) begin
      target_sel = jr_targetD;
    end else if (jumpD) begin
      target_sel = jump_targetD;
    end else begin
      target_sel = branch_targetD;
    end
    target = target_sel & ~32'h0000_0003;
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, imem request handshake with skid/drop handling, IF/ID register.
// Optional FETCH_CNT_EN adds fetched/squashed instruction counters.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stallD,
  input  logic               branch_takenD,
  input  logic [INSTR_W-1:0] branch_targetD,
  input  logic               jumpD,
  input  logic [INSTR_W-1:0] jump_targetD,
  input  logic               jrD,
  input  logic [INSTR_W-1:0] jr_targetD,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instrD,
  output logic [INSTR_W-1:0] pc_plus4D,
  output logic               validD
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]        fetched_cnt,
  output logic [31:0]        squashed_cnt
`endif
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] drop_addr_q, drop_addr_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [INSTR_W-1:0] skid_pc4_q, skid_pc4_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic               redirect;
  logic [INSTR_W-1:0] target;

  pc_redirect_mux u_redirect (
    .validD         (valid_q),
    .stallD         (stallD),
    .branch_takenD  (branch_takenD),
    .branch_targetD (branch_targetD),
    .jumpD          (jumpD),
    .jump_targetD   (jump_targetD),
    .jrD            (jrD),
    .jr_targetD     (jr_targetD),
    .redirect       (redirect),
    .target         (target)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    imem_req     = 1'b1;
    imem_addr    = pc_q;

    unique case (state_q)
      StReq: begin
        if (redirect) begin
          instr_d = NOP_INSTR;
          pc4_d   = '0;
          valid_d = 1'b0;
          pc_d    = target;
          // An unanswered request must still be retired before fetching the target.
          if (!imem_valid) begin
            drop_addr_d = pc_q;
            state_d     = StDrop;
          end
        end else if (imem_valid) begin
          pc_d = pc_q + 32'd4;
          if (!stallD) begin
            instr_d = imem_rdata;
            pc4_d   = pc_q + 32'd4;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_q + 32'd4;
            state_d      = StHold;
          end
        end else if (!stallD) begin
          instr_d = NOP_INSTR;
          pc4_d   = '0;
          valid_d = 1'b0;
        end
      end
      StHold: begin
        imem_req = 1'b0;
        if (!stallD) begin
          state_d = StReq;
          if (redirect) begin
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
            pc_d    = target;
          end else begin
            instr_d = skid_instr_q;
            pc4_d   = skid_pc4_q;
            valid_d = 1'b1;
          end
        end
      end
      StDrop: begin
        imem_addr = drop_addr_q;
        if (!stallD) begin
          instr_d = NOP_INSTR;
          pc4_d   = '0;
          valid_d = 1'b0;
        end
        if (imem_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  assign instrD    = instr_q;
  assign pc_plus4D = pc4_q;
  assign validD    = valid_q;

`ifdef FETCH_CNT_EN
  logic        fetch_inc, squash_inc;
  logic [31:0] fetched_q, squashed_q;

  // Squash covers a redirected live response, a dropped skid word and a drained wrong-path reply.
  assign fetch_inc  = ~redirect & ~stallD &
                      (((state_q == StReq) & imem_valid) | (state_q == StHold));
  assign squash_inc = ((state_q == StReq) & redirect & imem_valid) |
                      ((state_q == StHold) & redirect) |
                      ((state_q == StDrop) & imem_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else begin
      if (fetch_inc) fetched_q <= fetched_q + 32'd1;
      if (squash_inc) squashed_q <= squashed_q + 32'd1;
    end
  end

  assign fetched_cnt  = fetched_q;
  assign squashed_cnt = squashed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable imem model and an in-order scoreboard.
module tb_fetch_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stallD;
  logic        branch_takenD, jumpD, jrD;
  logic [31:0] branch_targetD, jump_targetD, jr_targetD;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrD, pc_plus4D;
  logic        validD;
`ifdef FETCH_CNT_EN
  logic [31:0] fetched_cnt, squashed_cnt;
`endif

  int unsigned lat = 0;
  int unsigned wait_cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stallD         (stallD),
    .branch_takenD  (branch_takenD),
    .branch_targetD (branch_targetD),
    .jumpD          (jumpD),
    .jump_targetD   (jump_targetD),
    .jrD            (jrD),
    .jr_targetD     (jr_targetD),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .instrD         (instrD),
    .pc_plus4D      (pc_plus4D),
    .validD         (validD)
`ifdef FETCH_CNT_EN
    ,
    .fetched_cnt    (fetched_cnt),
    .squashed_cnt   (squashed_cnt)
`endif
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // imem answers after `lat` waiting cycles; reset drops any outstanding request.
  always @(posedge clk) begin
    if (reset || !imem_req || imem_valid) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign imem_valid = imem_req && (wait_cnt >= lat);
  assign imem_rdata = imem_valid ? word_at(imem_addr) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Settle, check address stability and decode consumption, then advance one clock.
  task automatic tick();
    logic [31:0] a;
    #1;
    if (prev_wait) begin
      check("req_held", imem_req, 1);
      check("addr_stable", imem_addr, prev_addr);
    end
    if (validD && !stallD && !reset) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL sb_extra: observed instr %h expected none", instrD);
      end else begin
        a = exp_q.pop_front();
        check("sb_instr", instrD, word_at(a));
        check("sb_pc4", pc_plus4D, a + 32'd4);
      end
    end
    prev_wait = imem_req && !imem_valid && !reset;
    prev_addr = imem_addr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stallD = 1'b0;
    branch_takenD = 1'b0; jumpD = 1'b0; jrD = 1'b0;
    branch_targetD = '0; jump_targetD = '0; jr_targetD = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_valid", validD, 0);
    check("rst_instr", instrD, NOP_INSTR);
    check("rst_pc4", pc_plus4D, 0);
    check("rst_req", imem_req, 1);
    check("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_CNT_EN
    check("rst_fcnt", fetched_cnt, 0);
    check("rst_scnt", squashed_cnt, 0);
`endif
    reset = 1'b0;
    exp_q.delete();

    // 1: zero-wait streaming
    for (int i = 0; i < 6; i++) begin
      check("t1_addr", imem_addr, 32'(4 * i));
      check("t1_valid", validD, (i > 0));
      exp_q.push_back(32'(4 * i));
      tick();
    end

    // 2: latency 3, address held while waiting
    lat = 3;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        check("t2_addr", imem_addr, 32'(24 + 4 * k));
        check("t2_req", imem_req, 1);
        check("t2_valid", validD, (c == 0));
        if (c == 3) exp_q.push_back(32'(24 + 4 * k));
        tick();
      end
    end
    tick();
    check("t2_drained", exp_q.size(), 0);

    // 3: stall while the 0x8 response arrives
    reset = 1'b1; tick();
    reset = 1'b0; exp_q.delete(); lat = 0;
    exp_q.push_back(32'h0); tick();
    exp_q.push_back(32'h4); tick();
    stallD = 1'b1;
    check("t3_addr8", imem_addr, 32'h8);
    exp_q.push_back(32'h8); tick();
    check("t3_hold_req", imem_req, 0);
    check("t3_ifid_held", instrD, word_at(32'h4));
    tick();
    stallD = 1'b0;
    check("t3_hold_req2", imem_req, 0);
    tick();
    check("t3_addr_c", imem_addr, 32'hC);
    check("t3_req", imem_req, 1);
    check("t3_instr8", instrD, word_at(32'h8));
    check("t3_pc4", pc_plus4D, 32'hC);

    // 4: taken branch while 0xC outstanding with latency 2
    lat = 2;
    branch_takenD = 1'b1; branch_targetD = 32'h40;
    tick();
    branch_takenD = 1'b0;
    check("t4_drop_addr", imem_addr, 32'hC);
    check("t4_bubble", validD, 0);
    tick();
    check("t4_drop_addr2", imem_addr, 32'hC);
    tick();
    check("t4_target", imem_addr, 32'h40);
    check("t4_bubble2", validD, 0);
`ifdef FETCH_CNT_EN
    check("t4_scnt", squashed_cnt, 1);
`endif
    lat = 0;
    exp_q.push_back(32'h40); tick();

    // 5: jr beats j and branch; redirect held off by stall
    check("t5_addr", imem_addr, 32'h44);
    check("t5_valid", validD, 1);
`ifdef FETCH_CNT_EN
    check("t5_fcnt", fetched_cnt, 4);
`endif
    stallD = 1'b1;
    jrD = 1'b1; jr_targetD = 32'h103;
    jumpD = 1'b1; jump_targetD = 32'h300;
    branch_takenD = 1'b1; branch_targetD = 32'h200;
    tick();
    check("t5_stall_req", imem_req, 0);
    check("t5_stall_ifid", instrD, word_at(32'h40));
    tick();
    stallD = 1'b0;
    check("t5_hold_req", imem_req, 0);
    tick();
    jrD = 1'b0; jumpD = 1'b0; branch_takenD = 1'b0;
    check("t5_jr_target", imem_addr, 32'h100);
    check("t5_bubble", validD, 0);
`ifdef FETCH_CNT_EN
    check("t5_scnt", squashed_cnt, 2);
`endif
    exp_q.push_back(32'h100); tick();

    // PC wrap at the top of the address space
    check("wr_addr", imem_addr, 32'h104);
    jumpD = 1'b1; jump_targetD = 32'hFFFF_FFFC;
    tick();
    jumpD = 1'b0;
    check("wr_top", imem_addr, 32'hFFFF_FFFC);
    check("wr_bubble", validD, 0);
`ifdef FETCH_CNT_EN
    check("wr_scnt", squashed_cnt, 3);
`endif
    exp_q.push_back(32'hFFFF_FFFC); tick();
    check("wr_zero", imem_addr, 32'h0);
    exp_q.push_back(32'h0); tick();

    // 6: reset while a wrong-path request is being drained
    check("t6_addr", imem_addr, 32'h4);
    lat = 3;
    branch_takenD = 1'b1; branch_targetD = 32'h80;
    tick();
    branch_takenD = 1'b0;
    check("t6_drop_addr", imem_addr, 32'h4);
    check("t6_drop_req", imem_req, 1);
`ifdef FETCH_CNT_EN
    check("t6_fcnt", fetched_cnt, 7);
`endif
    reset = 1'b1;
    tick();
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_valid", validD, 0);
    check("t6_rst_instr", instrD, NOP_INSTR);
`ifdef FETCH_CNT_EN
    check("t6_rst_fcnt", fetched_cnt, 0);
    check("t6_rst_scnt", squashed_cnt, 0);
`endif
    reset = 1'b0;
    check("t6_drained", exp_q.size(), 0);
    exp_q.delete();
    lat = 0;
    exp_q.push_back(32'h0); tick();
    check("t6_addr4", imem_addr, 32'h4);
    exp_q.push_back(32'h4); tick();
    tick();
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
